uart_rx_cmd_decoder: RTL and testbench

Command decoder sitting directly downstream of the UART receiver: it consumes the received byte stream (`data_valid` / `P_data`), parses multi-byte command frames, and issues register-file writes and reads and ALU operations. Read and ALU results are pushed byte-wise into the TX-side result FIFO. It is the RX half of the system controller and runs in the reference (system) clock domain, after the RX byte has been synchronised.

---
 rtl/uart_rx_cmd_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_cmd_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_decoder.sv
// Command decoder behind the UART receiver: parses AA/BB/CC/DD frames into
// register-file accesses and ALU operations, and pushes results byte-wise to the TX FIFO.
module uart_rx_cmd_decoder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    input  logic                  rf_rd_valid,
    input  logic [DATA_W-1:0]     rf_rd_data,
    output logic                  alu_en,
    output logic [3:0]            alu_fun,
    output logic                  clk_gate_en,
    input  logic                  alu_out_valid,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  res_full,
    output logic                  res_wr_en,
    output logic [DATA_W-1:0]     res_data,
    output logic                  cmd_err
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_ADDR  = 4'd1;
    localparam logic [3:0] WR_DATA  = 4'd2;
    localparam logic [3:0] RD_ADDR  = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] OP_A     = 4'd5;
    localparam logic [3:0] OP_B     = 4'd6;
    localparam logic [3:0] ALU_FUN  = 4'd7;
    localparam logic [3:0] ALU_WAIT = 4'd8;
    localparam logic [3:0] RES_LSB  = 4'd9;
    localparam logic [3:0] RES_MSB  = 4'd10;

    localparam logic [DATA_W-1:0] OPC_WR  = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] OPC_RD  = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] OPC_ALU = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] OPC_FUN = DATA_W'(8'hDD);

    logic [3:0]          state_r;
    logic [3:0]          state_nxt_s;
    logic                err_s;
    logic                gate_nxt_s;
    logic [2*DATA_W-1:0] res_hold_r;

    // Next-state, protocol-error and clock-gate decode.
    // Result states are entered with the first push already issued when the FIFO has room,
    // so RES_LSB / RES_MSB only hold what is still waiting for space.
    always_comb begin
        state_nxt_s = state_r;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OPC_WR) begin
                        state_nxt_s = WR_ADDR;
                    end else if (rx_data == OPC_RD) begin
                        state_nxt_s = RD_ADDR;
                    end else if (rx_data == OPC_ALU) begin
                        state_nxt_s = OP_A;
                    end else if (rx_data == OPC_FUN) begin
                        state_nxt_s = ALU_FUN;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_ADDR:  state_nxt_s = rx_valid ? WR_DATA : WR_ADDR;
            WR_DATA:  state_nxt_s = rx_valid ? IDLE : WR_DATA;
            RD_ADDR:  state_nxt_s = rx_valid ? RD_WAIT : RD_ADDR;
            RD_WAIT: begin
                err_s = rx_valid;
                if (rf_rd_valid) begin
                    state_nxt_s = res_full ? RES_MSB : IDLE;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            OP_A:     state_nxt_s = rx_valid ? OP_B : OP_A;
            OP_B:     state_nxt_s = rx_valid ? ALU_FUN : OP_B;
            ALU_FUN:  state_nxt_s = rx_valid ? ALU_WAIT : ALU_FUN;
            ALU_WAIT: begin
                err_s = rx_valid;
                if (alu_out_valid) begin
                    state_nxt_s = res_full ? RES_LSB : RES_MSB;
                end else begin
                    state_nxt_s = ALU_WAIT;
                end
            end
            RES_LSB: begin
                err_s       = rx_valid;
                state_nxt_s = res_full ? RES_LSB : RES_MSB;
            end
            RES_MSB: begin
                err_s       = rx_valid;
                state_nxt_s = res_full ? RES_MSB : IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
        gate_nxt_s = (state_nxt_s == ALU_FUN) || (state_nxt_s == ALU_WAIT) ||
                     ((state_nxt_s == OP_A) && (state_r != OP_A));
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            rf_addr     <= '0;
            rf_wr_data  <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= 4'd0;
            clk_gate_en <= 1'b0;
            res_wr_en   <= 1'b0;
            res_data    <= '0;
            cmd_err     <= 1'b0;
            res_hold_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            clk_gate_en <= gate_nxt_s;
            cmd_err     <= err_s;
            rf_wr_en    <= 1'b0;
            rf_rd_en    <= 1'b0;
            alu_en      <= 1'b0;
            res_wr_en   <= 1'b0;
            case (state_r)
                WR_ADDR: begin
                    if (rx_valid) rf_addr <= rx_data[ADDR_W-1:0];
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_data <= rx_data;
                    end
                end
                RD_ADDR: begin
                    if (rx_valid) begin
                        rf_rd_en <= 1'b1;
                        rf_addr  <= rx_data[ADDR_W-1:0];
                    end
                end
                RD_WAIT: begin
                    // A read result travels in the upper byte so RES_MSB serves both paths.
                    if (rf_rd_valid) begin
                        res_hold_r <= {rf_rd_data, {DATA_W{1'b0}}};
                        if (!res_full) begin
                            res_wr_en <= 1'b1;
                            res_data  <= rf_rd_data;
                        end
                    end
                end
                OP_A: begin
                    if (rx_valid) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= ADDR_W'(0);
                        rf_wr_data <= rx_data;
                    end
                end
                OP_B: begin
                    if (rx_valid) begin
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= ADDR_W'(1);
                        rf_wr_data <= rx_data;
                    end
                end
                ALU_FUN: begin
                    if (rx_valid) begin
                        alu_en  <= 1'b1;
                        alu_fun <= rx_data[3:0];
                    end
                end
                ALU_WAIT: begin
                    if (alu_out_valid) begin
                        res_hold_r <= alu_out;
                        if (!res_full) begin
                            res_wr_en <= 1'b1;
                            res_data  <= alu_out[DATA_W-1:0];
                        end
                    end
                end
                RES_LSB: begin
                    if (!res_full) begin
                        res_wr_en <= 1'b1;
                        res_data  <= res_hold_r[DATA_W-1:0];
                    end
                end
                RES_MSB: begin
                    if (!res_full) begin
                        res_wr_en <= 1'b1;
                        res_data  <= res_hold_r[2*DATA_W-1:DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: table of frames with scoreboard-checked strobes,
// plus cycle-exact sequences for timing, clock gating, backpressure, errors and reset.
module tb_uart_rx_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rf_wr_en, rf_rd_en, alu_en, clk_gate_en, res_wr_en, cmd_err;
    logic [3:0]  rf_addr, alu_fun;
    logic [7:0]  rf_wr_data, res_data;
    logic        rf_rd_valid = 1'b0;
    logic [7:0]  rf_rd_data = 8'h00;
    logic        alu_out_valid = 1'b0;
    logic [15:0] alu_out = 16'h0000;
    logic        res_full = 1'b0;

    int compared = 0;
    int mismatched = 0;

    uart_rx_cmd_decoder #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_valid(rf_rd_valid), .rf_rd_data(rf_rd_data),
        .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
        .alu_out_valid(alu_out_valid), .alu_out(alu_out),
        .res_full(res_full), .res_wr_en(res_wr_en), .res_data(res_data), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    localparam int K_WR = 1, K_RD = 2, K_ALU = 3, K_RES = 4, K_ERR = 5;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [31:0] bytes;
        int          nb;
        logic [15:0] resp;
        int          n_ev;
        ev_t [4:0]   ev;
    } vec_t;

    ev_t exp_q[$];
    vec_t vecs[8];

    function automatic ev_t mk_ev(input int k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = 3'(k);
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] bytes, input int nb, input logic [15:0] resp,
                                    input int n, input ev_t e0, input ev_t e1, input ev_t e2,
                                    input ev_t e3, input ev_t e4);
        vec_t v;
        v.bytes = bytes;
        v.nb    = nb;
        v.resp  = resp;
        v.n_ev  = n;
        v.ev[0] = e0;
        v.ev[1] = e1;
        v.ev[2] = e2;
        v.ev[3] = e3;
        v.ev[4] = e4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input ev_t act);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got kind=%0d a=%h d=%h expected nothing", act.kind, act.a, act.d);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                mismatched++;
                $display("FAIL scoreboard: got kind=%0d a=%h d=%h expected kind=%0d a=%h d=%h",
                         act.kind, act.a, act.d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Scoreboard monitor: every strobe is matched against the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_err)   sb_check(mk_ev(K_ERR, 4'h0, 8'h00));
            if (rf_wr_en)  sb_check(mk_ev(K_WR, rf_addr, rf_wr_data));
            if (rf_rd_en)  sb_check(mk_ev(K_RD, rf_addr, 8'h00));
            if (alu_en)    sb_check(mk_ev(K_ALU, alu_fun, 8'h00));
            if (res_wr_en) sb_check(mk_ev(K_RES, 4'h0, res_data));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        rf_rd_valid = 1'b1;
        rf_rd_data  = d;
        @(negedge clk);
        rf_rd_valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        alu_out_valid = 1'b1;
        alu_out       = d;
        @(negedge clk);
        alu_out_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({name, "_drained"}, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    initial begin
        ev_t z;
        logic [7:0] op;
        z = '0;
        vecs[0] = mk_vec(32'hAA053C00, 3, 16'h0000, 1, mk_ev(K_WR, 4'h5, 8'h3C), z, z, z, z);
        vecs[1] = mk_vec(32'hAAF78100, 3, 16'h0000, 1, mk_ev(K_WR, 4'h7, 8'h81), z, z, z, z);
        vecs[2] = mk_vec(32'hBB020000, 2, 16'h007E, 2, mk_ev(K_RD, 4'h2, 8'h00),
                         mk_ev(K_RES, 4'h0, 8'h7E), z, z, z);
        vecs[3] = mk_vec(32'hBB1F0000, 2, 16'h00A5, 2, mk_ev(K_RD, 4'hF, 8'h00),
                         mk_ev(K_RES, 4'h0, 8'hA5), z, z, z);
        vecs[4] = mk_vec(32'hCC123401, 4, 16'h0046, 5, mk_ev(K_WR, 4'h0, 8'h12),
                         mk_ev(K_WR, 4'h1, 8'h34), mk_ev(K_ALU, 4'h1, 8'h00),
                         mk_ev(K_RES, 4'h0, 8'h46), mk_ev(K_RES, 4'h0, 8'h00));
        vecs[5] = mk_vec(32'hDD3A0000, 2, 16'hBEEF, 3, mk_ev(K_ALU, 4'hA, 8'h00),
                         mk_ev(K_RES, 4'h0, 8'hEF), mk_ev(K_RES, 4'h0, 8'hBE), z, z);
        vecs[6] = mk_vec(32'h55000000, 1, 16'h0000, 1, mk_ev(K_ERR, 4'h0, 8'h00), z, z, z, z);
        vecs[7] = mk_vec(32'hDDF50000, 2, 16'h0100, 3, mk_ev(K_ALU, 4'h5, 8'h00),
                         mk_ev(K_RES, 4'h0, 8'h00), mk_ev(K_RES, 4'h0, 8'h01), z, z);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {9'd0, rf_wr_en, rf_rd_en, alu_en, clk_gate_en, res_wr_en, cmd_err, 1'b0}, 16'd0);
        chk("rst_addr_fun", {rf_addr, alu_fun, 8'h00}, 16'd0);
        chk("rst_data", {rf_wr_data, res_data}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vecs[i].n_ev; j++) exp_q.push_back(vecs[i].ev[j]);
            op = vecs[i].bytes[31:24];
            for (int b = 0; b < vecs[i].nb; b++) send_byte(vecs[i].bytes[31-8*b -: 8]);
            if (op == 8'hBB) begin
                @(negedge clk);
                pulse_rd(vecs[i].resp[7:0]);
            end else if (op == 8'hCC || op == 8'hDD) begin
                @(negedge clk);
                pulse_alu(vecs[i].resp);
            end
            wait_drain($sformatf("vec%0d", i));
        end

        // Write strobe timing: one cycle, the cycle after the data byte
        exp_q.push_back(mk_ev(K_WR, 4'h5, 8'h3C));
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        chk("wr_strobe", {7'd0, rf_wr_en, rf_addr, 4'd0}, {7'd0, 1'b1, 4'h5, 4'd0});
        chk("wr_data", {8'h00, rf_wr_data}, 16'h003C);
        @(negedge clk);
        chk("wr_one_cycle", {15'd0, rf_wr_en}, 16'd0);
        chk("wr_addr_hold", {12'd0, rf_addr}, 16'h0005);
        wait_drain("wr_timing");

        // ALU with operands: clock-gate profile and result timing
        exp_q.push_back(mk_ev(K_WR, 4'h0, 8'h12));
        exp_q.push_back(mk_ev(K_WR, 4'h1, 8'h34));
        exp_q.push_back(mk_ev(K_ALU, 4'h1, 8'h00));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h46));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h00));
        send_byte(8'hCC);
        chk("cg_opa_first", {15'd0, clk_gate_en}, 16'd1);
        @(negedge clk);
        chk("cg_opa_second", {15'd0, clk_gate_en}, 16'd0);
        send_byte(8'h12);
        chk("cg_opb", {15'd0, clk_gate_en}, 16'd0);
        send_byte(8'h34);
        chk("cg_alufun", {15'd0, clk_gate_en}, 16'd1);
        send_byte(8'h01);
        chk("alu_strobe", {7'd0, alu_en, clk_gate_en, 3'd0, alu_fun}, {7'd0, 1'b1, 1'b1, 3'd0, 4'h1});
        @(negedge clk);
        chk("cg_aluwait", {7'd0, alu_en, clk_gate_en, 7'd0}, {7'd0, 1'b0, 1'b1, 7'd0});
        pulse_alu(16'h0046);
        chk("alu_res_lsb", {res_wr_en, clk_gate_en, 6'd0, res_data}, {1'b1, 1'b0, 6'd0, 8'h46});
        @(negedge clk);
        chk("alu_res_msb", {res_wr_en, 7'd0, res_data}, {1'b1, 7'd0, 8'h00});
        wait_drain("alu_ops");

        // Backpressure: known last byte, then DD frame with the FIFO full for three cycles
        exp_q.push_back(mk_ev(K_RD, 4'h3, 8'h00));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h5A));
        send_byte(8'hBB);
        send_byte(8'h03);
        pulse_rd(8'h5A);
        wait_drain("bp_pre");
        exp_q.push_back(mk_ev(K_ALU, 4'h3, 8'h00));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h34));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h12));
        send_byte(8'hDD);
        send_byte(8'h03);
        res_full = 1'b1;
        pulse_alu(16'h1234);
        for (int c = 0; c < 2; c++) begin
            chk("bp_hold", {res_wr_en, 7'd0, res_data}, {1'b0, 7'd0, 8'h5A});
            @(negedge clk);
        end
        chk("bp_hold", {res_wr_en, 7'd0, res_data}, {1'b0, 7'd0, 8'h5A});
        res_full = 1'b0;
        @(negedge clk);
        chk("bp_push_lsb", {res_wr_en, 7'd0, res_data}, {1'b1, 7'd0, 8'h34});
        @(negedge clk);
        chk("bp_push_msb", {res_wr_en, 7'd0, res_data}, {1'b1, 7'd0, 8'h12});
        @(negedge clk);
        chk("bp_done", {res_wr_en, 7'd0, res_data}, {1'b0, 7'd0, 8'h12});
        wait_drain("backpressure");

        // Byte arriving in RD_WAIT is dropped with an error; the read still completes
        exp_q.push_back(mk_ev(K_RD, 4'h4, 8'h00));
        exp_q.push_back(mk_ev(K_ERR, 4'h0, 8'h00));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'h99));
        send_byte(8'hBB);
        send_byte(8'h04);
        send_byte(8'h77);
        chk("rdwait_err", {15'd0, cmd_err}, 16'd1);
        pulse_rd(8'h99);
        chk("rdwait_res", {res_wr_en, 7'd0, res_data}, {1'b1, 7'd0, 8'h99});
        wait_drain("rdwait");

        // Back-to-back write frames
        exp_q.push_back(mk_ev(K_WR, 4'h1, 8'h11));
        exp_q.push_back(mk_ev(K_WR, 4'h2, 8'h22));
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h22);
        wait_drain("b2b");

        // Reset mid-frame aborts the write; a later read decodes normally
        send_byte(8'hAA);
        send_byte(8'h05);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        chk("rst_abort", {15'd0, rf_wr_en}, 16'd0);
        @(negedge clk);
        chk("rst_abort_later", {15'd0, rf_wr_en}, 16'd0);
        exp_q.push_back(mk_ev(K_RD, 4'h9, 8'h00));
        exp_q.push_back(mk_ev(K_RES, 4'h0, 8'hC3));
        send_byte(8'hBB);
        send_byte(8'h09);
        chk("post_rst_rd", {11'd0, rf_rd_en, rf_addr}, {11'd0, 1'b1, 4'h9});
        pulse_rd(8'hC3);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
